// File: rtl/mlp_frame_sequencer.sv
// Frame sequencer wrapping a combinational printed-MLP classifier:
// loads features beat-by-beat, settles, captures argmax, returns it.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   s_valid/s_ready     feature beat handshake
//   s_data, s_last      feature value, final beat of frame
//   mlp_inp             packed features to classifier (slot k at FEAT_W*k)
//   mlp_out             classifier argmax (combinational from mlp_inp)
//   m_valid/m_ready     class result handshake
//   m_class             captured class
//   err_count           malformed frames seen, saturating at 255
module mlp_frame_sequencer #(
  parameter int N_FEAT     = 7,
  parameter int FEAT_W     = 4,
  parameter int CLS_W      = 2,
  parameter int SETTLE_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [FEAT_W-1:0]        s_data,
  input  logic                     s_last,
  output logic [N_FEAT*FEAT_W-1:0] mlp_inp,
  input  logic [CLS_W-1:0]         mlp_out,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [CLS_W-1:0]         m_class,
  output logic [7:0]               err_count
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

  typedef enum logic [1:0] {
    LOAD,
    DRAIN,
    SETTLE,
    OUT
  } state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   idx;
  logic [7:0]         sc;

  logic beat;
  logic at_end;
  logic sc_done;
  logic do_write;
  logic do_short;
  logic do_long;
  logic do_cap;
  logic do_hs;
  logic idx_clr;

  assign s_ready = (state == LOAD) || (state == DRAIN);
  assign beat    = s_valid && s_ready;
  assign at_end  = (idx == IDX_W'(N_FEAT - 1));
  assign sc_done = (sc == 8'(SETTLE_CYC - 1));

  always_comb begin
    state_d  = state;
    do_write = 1'b0;
    do_short = 1'b0;
    do_long  = 1'b0;
    do_cap   = 1'b0;
    do_hs    = 1'b0;
    idx_clr  = 1'b0;
    unique case (state)
      LOAD: begin
        if (beat) begin
          unique case (1'b1)
            at_end && s_last: begin
              do_write = 1'b1;
              idx_clr  = 1'b1;
              state_d  = SETTLE;
            end
            at_end && !s_last: begin
              do_write = 1'b1;
              do_long  = 1'b1;
              idx_clr  = 1'b1;
              state_d  = DRAIN;
            end
            !at_end && s_last: begin
              do_short = 1'b1;
              idx_clr  = 1'b1;
            end
            default: begin
              do_write = 1'b1;
            end
          endcase
        end
      end
      DRAIN: begin
        if (beat && s_last) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sc_done) begin
          do_cap  = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (m_ready) begin
          do_hs   = 1'b1;
          state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (idx_clr) begin
      idx <= '0;
    end else if (do_write) begin
      idx <= idx + IDX_W'(1);
    end
  end

  // Short frames wipe the whole vector so no partial data reaches
  // the classifier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mlp_inp <= '0;
    end else if (do_short) begin
      mlp_inp <= '0;
    end else if (do_write) begin
      for (int k = 0; k < N_FEAT; k++) begin
        if (idx == IDX_W'(k)) begin
          mlp_inp[FEAT_W*k +: FEAT_W] <= s_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc <= '0;
    end else if (state == SETTLE) begin
      sc <= sc_done ? 8'd0 : sc + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_class <= '0;
    end else if (do_cap) begin
      m_valid <= 1'b1;
      m_class <= mlp_out;
    end else if (do_hs) begin
      m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if ((do_short || do_long) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule
